// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM driver slice.
// Contents: default channel count and duty width, channel index type, duty type.
package led_pkg;

  localparam int unsigned LED_CHANNELS = 8;
  localparam int unsigned LED_DUTY_W   = 8;

  typedef logic [2:0]            led_chan_t;
  typedef logic [LED_DUTY_W-1:0] led_duty_t;

endpackage

// File: rtl/led_pwm_driver_if.sv
// Duty-value write port of the LED PWM driver (valid/ready).
// Signals:
//   duty_valid - write request (master -> slave)
//   duty_ready - slave can accept this cycle
//   duty_chan  - target channel index
//   duty_data  - new duty value
// Modports: master (upstream pattern source), slave (led_pwm_driver).
interface led_pwm_driver_if
  import led_pkg::*;
#(
  parameter int unsigned DutyW = LED_DUTY_W
) ();

  logic             duty_valid;
  logic             duty_ready;
  led_chan_t        duty_chan;
  logic [DutyW-1:0] duty_data;

  modport master (
    output duty_valid,
    output duty_chan,
    output duty_data,
    input  duty_ready
  );

  modport slave (
    input  duty_valid,
    input  duty_chan,
    input  duty_data,
    output duty_ready
  );

endinterface

// File: rtl/led_pwm_timebase.sv
// Prescaler and PWM phase counter shared by all LED channels.
// Ports:
//   clk_i      - system clock
//   rst_ni     - asynchronous active-low reset
//   tick_o     - high in the last prescaler cycle of each PWM tick
//   boundary_o - high in the last cycle of each PWM period
//   pwm_cnt_o  - current PWM phase (0 .. 2^DutyW-1)
module led_pwm_timebase #(
  parameter int unsigned DutyW    = 8,
  parameter int unsigned Prescale = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             tick_o,
  output logic             boundary_o,
  output logic [DutyW-1:0] pwm_cnt_o
);

  // A one-bit counter that never leaves zero keeps Prescale == 1 legal.
  localparam int unsigned   PreW   = (Prescale > 1) ? $clog2(Prescale) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(Prescale - 1);

  logic [PreW-1:0]  pre_cnt_q, pre_cnt_d;
  logic [DutyW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             tick;

  always_comb begin
    tick      = (pre_cnt_q == PreMax);
    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign tick_o     = tick;
  assign boundary_o = tick && (pwm_cnt_q == '1);
  assign pwm_cnt_o  = pwm_cnt_q;

endmodule

// File: rtl/led_pwm_driver.sv
// Eight-channel LED brightness driver: per-channel duty values arrive over a
// valid/ready port, are double-buffered (pending -> active) at PWM period
// boundaries and turned into registered active-high PWM outputs.
// Build option: define LED_PWM_FADE_EN to make active step one LSB per period
// toward pending instead of loading it directly.
// Ports:
//   clk_i          - system clock
//   rst_ni         - asynchronous active-low reset
//   enable_i       - low forces all LEDs off; timing keeps running
//   duty_if        - duty write port (slave modport)
//   led_o          - registered PWM outputs
//   period_start_o - one-cycle pulse in the first cycle of each PWM period
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int unsigned Channels = LED_CHANNELS,
  parameter int unsigned DutyW    = LED_DUTY_W,
  parameter int unsigned Prescale = 256
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  led_pwm_driver_if.slave     duty_if,
  output logic [Channels-1:0] led_o,
  output logic                period_start_o
);

  logic             tick, boundary;
  logic [DutyW-1:0] pwm_cnt, pwm_cnt_next;

  led_pwm_timebase #(
    .DutyW    (DutyW),
    .Prescale (Prescale)
  ) u_timebase (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .tick_o     (tick),
    .boundary_o (boundary),
    .pwm_cnt_o  (pwm_cnt)
  );

  logic                            ready_en_q;
  logic                            accept;
  logic [Channels-1:0][DutyW-1:0]  pending_q, pending_d;
  logic [Channels-1:0][DutyW-1:0]  active_q, active_d;
  logic [Channels-1:0]             led_q, led_d;
  logic                            period_start_q;

  // ready_en_q holds ready low until the first edge after reset release.
  assign duty_if.duty_ready = ready_en_q && !boundary;
  assign accept             = duty_if.duty_valid && duty_if.duty_ready;
  assign pwm_cnt_next       = tick ? pwm_cnt + 1'b1 : pwm_cnt;

  always_comb begin
    pending_d = pending_q;
    active_d  = active_q;
    led_d     = '0;
    for (int i = 0; i < int'(Channels); i++) begin
      // Indices >= Channels match no channel, so such writes vanish.
      if (accept && (int'(duty_if.duty_chan) == i)) begin
        pending_d[i] = duty_if.duty_data;
      end
      if (boundary) begin
`ifdef LED_PWM_FADE_EN
        if (active_q[i] < pending_q[i]) begin
          active_d[i] = active_q[i] + 1'b1;
        end else if (active_q[i] > pending_q[i]) begin
          active_d[i] = active_q[i] - 1'b1;
        end
`else
        active_d[i] = pending_q[i];
`endif
      end
      // Compare against next-state phase/duty so the registered LED lines up
      // with the counter: new duties show in the period_start cycle, phase 0.
      led_d[i] = enable_i && (pwm_cnt_next < active_d[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_en_q     <= 1'b0;
      pending_q      <= '0;
      active_q       <= '0;
      led_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      ready_en_q     <= 1'b1;
      pending_q      <= pending_d;
      active_q       <= active_d;
      led_q          <= led_d;
      period_start_q <= boundary;
    end
  end

  assign led_o          = led_q;
  assign period_start_o = period_start_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
module tb_led_pwm_driver;

  localparam int Period = 256;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b1;
  logic [7:0] led;
  logic       ps;

  led_pwm_driver_if #(.DutyW(8)) duty_if ();

  led_pwm_driver #(
    .Channels (8),
    .DutyW    (8),
    .Prescale (1)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (en),
    .duty_if        (duty_if),
    .led_o          (led),
    .period_start_o (ps)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: k = rising edges since reset release; phase = k mod Period.
  int         k;
  bit         rdy_en;
  int         pend [8];
  int         act  [8];
  logic [7:0] exp_led;
  logic       exp_ps;

  function automatic logic exp_ready();
    return rdy_en && ((k % Period) != Period - 1);
  endfunction

  // Expected on-time in the n-th period after a write of t onto an idle channel.
  function automatic int exp_on(int t, int n);
`ifdef LED_PWM_FADE_EN
    return (t < n) ? t : n;
`else
    return t + 0 * n;
`endif
  endfunction

  task automatic model_clear();
    k = 0; rdy_en = 0; exp_led = '0; exp_ps = 0;
    for (int i = 0; i < 8; i++) begin pend[i] = 0; act[i] = 0; end
  endtask

  task automatic step();
    bit bnd, acc;
    @(posedge clk);
    if (rst_n) begin
      bnd = ((k % Period) == Period - 1);
      acc = duty_if.duty_valid && rdy_en && !bnd;
      if (bnd) begin
        for (int i = 0; i < 8; i++) begin
`ifdef LED_PWM_FADE_EN
          if (act[i] < pend[i]) act[i]++;
          else if (act[i] > pend[i]) act[i]--;
`else
          act[i] = pend[i];
`endif
        end
      end
      if (acc) pend[duty_if.duty_chan] = int'(duty_if.duty_data);
      rdy_en = 1;
      k++;
      for (int i = 0; i < 8; i++) exp_led[i] = en && ((k % Period) < act[i]);
      exp_ps = ((k % Period) == 0);
    end
    #1;
  endtask

  task automatic do_reset();
    duty_if.duty_valid = 0;
    rst_n = 0;
    model_clear();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic write(input int ch, input int d);
    bit r;
    bit done = 0;
    duty_if.duty_valid = 1;
    duty_if.duty_chan  = ch[2:0];
    duty_if.duty_data  = d[7:0];
    for (int n = 0; n < 4 && !done; n++) begin
      r = duty_if.duty_ready;
      step();
      done = r;
    end
    duty_if.duty_valid = 0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL write_accept: ch %0d got no ready in 4 cycles, required accept", ch);
    end
  endtask

  // Waits for period_start, then sums LED high cycles over that whole period.
  // Returns in the last cycle of the period.
  task automatic run_period(output int on [8]);
    int n = 0;
    for (int i = 0; i < 8; i++) on[i] = 0;
    step();
    while (ps !== 1'b1 && n < 600) begin step(); n++; end
    checks++;
    if (ps !== 1'b1) begin
      failures++;
      $display("FAIL period_wait: period_start got %b, required 1 within 600 cycles", ps);
    end
    for (int c = 0; c < Period; c++) begin
      if (c > 0) step();
      for (int i = 0; i < 8; i++) on[i] += int'(led[i]);
    end
  endtask

  task automatic test_reset();
    duty_if.duty_valid = 0; duty_if.duty_chan = '0; duty_if.duty_data = '0;
    #2 rst_n = 0;
    model_clear();
    #1;
    checks += 3;
    if (led !== 8'h00) begin failures++; $display("FAIL reset_led: got %h required 00", led); end
    if (ps !== 1'b0) begin failures++; $display("FAIL reset_ps: got %b required 0", ps); end
    if (duty_if.duty_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready: got %b required 0", duty_if.duty_ready);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (duty_if.duty_ready !== 1'b0) begin
      failures++; $display("FAIL ready_before_edge: got %b required 0", duty_if.duty_ready);
    end
    step();
    checks++;
    if (duty_if.duty_ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_edge: got %b required 1", duty_if.duty_ready);
    end
  endtask

  task automatic test_idle();
    int nps = 0;
    en = 1;
    for (int c = 0; c < 600; c++) begin
      step();
      nps += int'(ps === 1'b1);
      checks++;
      if ({duty_if.duty_ready, ps, led} !== {exp_ready(), exp_ps, exp_led}) begin
        failures++;
        $display("FAIL idle: k=%0d got rdy/ps/led %b/%b/%h required %b/%b/%h", k,
                 duty_if.duty_ready, ps, led, exp_ready(), exp_ps, exp_led);
      end
    end
    checks++;
    if (nps != 2) begin failures++; $display("FAIL idle_ps_count: got %0d required 2", nps); end
  endtask

  task automatic test_duty_basic();
    int on [8];
    do_reset();
    write(0, 64);
    for (int p = 1; p <= 2; p++) begin
      run_period(on);
      checks++;
      if (on[0] != exp_on(64, p)) begin
        failures++; $display("FAIL basic_ch0: period %0d got %0d required %0d", p, on[0], exp_on(64, p));
      end
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (on[i] != 0) begin failures++; $display("FAIL basic_other: ch%0d got %0d required 0", i, on[i]); end
      end
    end
  endtask

  task automatic test_extremes();
    int on [8];
    do_reset();
    write(3, 0);
    write(4, 255);
    for (int p = 1; p <= 2; p++) begin
      run_period(on);
      checks += 3;
      if (on[3] != 0) begin failures++; $display("FAIL ext_ch3: got %0d required 0", on[3]); end
      if (on[4] != exp_on(255, p)) begin
        failures++; $display("FAIL ext_ch4: period %0d got %0d required %0d", p, on[4], exp_on(255, p));
      end
      if (led[4] !== 1'b0) begin failures++; $display("FAIL ext_last_cycle: got %b required 0", led[4]); end
    end
  endtask

  task automatic test_back_to_back_boundary();
    int on [8];
    int d = int'($urandom_range(1, 254));
    int lit = 0;
    int n = 0;
    do_reset();
    step();
    while ((k % Period) != Period - 1 && n < 600) begin step(); n++; end
    duty_if.duty_valid = 1; duty_if.duty_chan = 3'd2; duty_if.duty_data = d[7:0];
    checks++;
    if (duty_if.duty_ready !== 1'b0) begin
      failures++; $display("FAIL stall_ready_low: got %b required 0", duty_if.duty_ready);
    end
    step();
    checks += 2;
    if (duty_if.duty_ready !== 1'b1) begin
      failures++; $display("FAIL stall_ready_back: got %b required 1", duty_if.duty_ready);
    end
    if (ps !== 1'b1) begin failures++; $display("FAIL stall_ps: got %b required 1", ps); end
    lit += int'(led[2]);
    step();
    duty_if.duty_valid = 0;
    while ((k % Period) != Period - 1) begin lit += int'(led[2]); step(); end
    checks++;
    if (lit != 0) begin failures++; $display("FAIL stall_early_apply: got %0d required 0", lit); end
    run_period(on);
    checks++;
    if (on[2] != exp_on(d, 1)) begin
      failures++; $display("FAIL stall_apply: got %0d required %0d", on[2], exp_on(d, 1));
    end
  endtask

  task automatic test_enable();
    int on [8];
    int n = 0;
    do_reset();
    write(0, 200);
    run_period(on);
    for (int c = 0; c < 50; c++) step();
    en = 0;
    step();
    checks++;
    if (led !== 8'h00) begin failures++; $display("FAIL enable_off: got %h required 00", led); end
    while ((k % Period) != 0 && n < 600) begin step(); n++; end
    checks += 2;
    if (ps !== 1'b1) begin failures++; $display("FAIL enable_ps_spacing: got %b required 1", ps); end
    if (led !== 8'h00) begin failures++; $display("FAIL enable_off_hold: got %h required 00", led); end
    en = 1;
    step();
    checks++;
    if (led !== exp_led) begin failures++; $display("FAIL enable_on: got %h required %h", led, exp_led); end
  endtask

  task automatic test_reset_mid();
    int on [8];
    write(5, int'($urandom_range(100, 200)));
    run_period(on);
    for (int c = 0; c < 10; c++) step();
    rst_n = 0;
    model_clear();
    #1;
    checks += 3;
    if (led !== 8'h00) begin failures++; $display("FAIL rstmid_led: got %h required 00", led); end
    if (ps !== 1'b0) begin failures++; $display("FAIL rstmid_ps: got %b required 0", ps); end
    if (duty_if.duty_ready !== 1'b0) begin
      failures++; $display("FAIL rstmid_ready: got %b required 0", duty_if.duty_ready);
    end
    @(negedge clk);
    rst_n = 1;
    for (int p = 0; p < 2; p++) begin
      run_period(on);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (on[i] != 0) begin failures++; $display("FAIL rstmid_cleared: ch%0d got %0d required 0", i, on[i]); end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      duty_if.duty_valid = ($urandom_range(0, 3) == 0);
      duty_if.duty_chan  = 3'($urandom_range(0, 7));
      duty_if.duty_data  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 63) == 0) en = ~en;
      step();
      checks++;
      if ({duty_if.duty_ready, ps, led} !== {exp_ready(), exp_ps, exp_led}) begin
        failures++;
        $display("FAIL random: k=%0d got rdy/ps/led %b/%b/%h required %b/%b/%h", k,
                 duty_if.duty_ready, ps, led, exp_ready(), exp_ps, exp_led);
      end
    end
    duty_if.duty_valid = 0;
    en = 1;
  endtask

  task automatic test_fade();
    int on [8];
`ifdef LED_PWM_FADE_EN
    int up [5] = '{1, 2, 3, 4, 4};
    int dn [3] = '{3, 2, 2};
`else
    int up [5] = '{4, 4, 4, 4, 4};
    int dn [3] = '{2, 2, 2};
`endif
    do_reset();
    write(1, 4);
    for (int p = 0; p < 5; p++) begin
      run_period(on);
      checks++;
      if (on[1] != up[p]) begin failures++; $display("FAIL fade_up: period %0d got %0d required %0d", p, on[1], up[p]); end
    end
    write(1, 2);
    for (int p = 0; p < 3; p++) begin
      run_period(on);
      checks++;
      if (on[1] != dn[p]) begin failures++; $display("FAIL fade_down: period %0d got %0d required %0d", p, on[1], dn[p]); end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_duty_basic();
    test_extremes();
    test_back_to_back_boundary();
    test_enable();
    test_reset_mid();
    test_random();
    test_fade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
